// File: rtl/mem_pkg.sv
// Shared widths and FSM state encoding for the banked burst reader.
package mem_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int BANK_W = 2;
    localparam int IDX_W  = 8;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mem_rd_fifo.sv
// Small output buffer for returned bank data; each entry carries {last, data}.
// Storage is not reset: only pointers and occupancy are control state.
module mem_rd_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 9,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy tracking; callers never push when full or pop when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a push never targets the head entry while it is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign valid    = (count != '0);
    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/mem_burst_reader.sv
// Burst reader: turns one {addr, len} request into a run of single-byte bank
// reads and streams the returned bytes out through a small buffer, flagging
// the final beat. Reads are only issued when buffer space is guaranteed.
module mem_burst_reader #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int FIFO_D = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [mem_pkg::LEN_W-1:0]  req_len,
    output logic                       rd_en,
    output logic [mem_pkg::BANK_W-1:0] rd_bank,
    output logic [mem_pkg::IDX_W-1:0]  rd_index,
    input  logic [DATA_W-1:0]          rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    output logic                       busy
);

    import mem_pkg::*;

    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam int OCC_W  = CNT_W + 1;
    localparam int BEAT_W = LEN_W + 1;
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_D);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [BEAT_W-1:0]  beats_left;
    logic               accept;
    logic               last_issue;
    logic               pop;
    logic [OCC_W-1:0]   occ;
    logic               vld_p1;
    logic               last_p1;
    logic [CNT_W-1:0]   fifo_count;
    logic [DATA_W:0]    fifo_dout;
    logic               fifo_last;

    // Occupancy after this cycle's pop: buffered + in flight - leaving now.
    // out_ready reaches rd_en only through this pop term.
    assign pop = out_valid & out_ready;
    assign occ = OCC_W'(fifo_count) + OCC_W'(vld_p1) - OCC_W'(pop);

    assign busy     = (state != IDLE);
    assign rd_bank  = addr[IDX_W +: BANK_W];
    assign rd_index = addr[IDX_W-1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and strobes: accept in IDLE, issue reads in READ, wait for the last pop in DRAIN.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        rd_en      = 1'b0;
        last_issue = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if ((beats_left != '0) && (occ < OCC_LIMIT)) begin
                    rd_en = 1'b1;
                    if (beats_left == BEAT_W'(1)) begin
                        last_issue = 1'b1;
                        state_nxt  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/beat counters and the read-return valid; address wraps naturally at ADDR_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            beats_left <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (accept) begin
                addr       <= req_addr;
                beats_left <= BEAT_W'(req_len) + BEAT_W'(1);
            end else if (rd_en) begin
                addr       <= addr + ADDR_W'(1);
                beats_left <= beats_left - BEAT_W'(1);
            end
        end
    end

    // ---- stage p1: bank data returns, tagged with its last-beat marker ----
    always_ff @(posedge clk) begin
        last_p1 <= last_issue;
    end

    mem_rd_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data ({last_p1, rd_data}),
        .pop       (pop),
        .valid     (out_valid),
        .pop_data  (fifo_dout),
        .count     (fifo_count)
    );

    assign fifo_last = fifo_dout[DATA_W];
    assign out_data  = fifo_dout[DATA_W-1:0];
    assign out_last  = out_valid & fifo_last;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: bank memory model plus a scoreboard of expected
// read addresses and output beats, one task per scenario.
module tb_mem_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_addr;
    logic [7:0] req_len;
    logic       rd_en;
    logic [1:0] rd_bank;
    logic [7:0] rd_index;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] bank [4][256];
    logic [9:0] rd_q  [$];
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    mem_burst_reader #(.ADDR_W(10), .DATA_W(8), .FIFO_D(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Bank model: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) rd_data <= rd_en ? bank[rd_bank][rd_index] : 8'hEE;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic fill_index();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 256; i++) bank[b][i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 256; i++) bank[b][i] = 8'($urandom);
    endtask

    function automatic void push_burst(input logic [9:0] a, input logic [7:0] l);
        logic [9:0] p;
        for (int i = 0; i <= int'(l); i++) begin
            p = a + 10'(i);
            rd_q.push_back(p);
            exp_q.push_back({(i == int'(l)), bank[p[9:8]][p[7:0]]});
        end
    endfunction

    task automatic issue(input logic [9:0] a, input logic [7:0] l);
        int w;
        w = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_len = l;
        #1;
        while (!req_ready && w < 50) begin
            @(negedge clk); #1; w++;
        end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_accept got=%b exp=1", req_ready);
        end else begin
            push_burst(a, l);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({req_ready, rd_en, out_valid, out_last, busy} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_state got=%b exp=10000", {req_ready, rd_en, out_valid, out_last, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called directly after reset release: the request is offered in that very cycle.
    task automatic test_single();
        bank[2][8'hBD] = 8'hBF;
        req_valid = 1'b1; req_addr = 10'h2BD; req_len = 8'd0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_accept got=%b exp=1", req_ready); end
        @(negedge clk); req_valid = 1'b0; #1;
        n_cmp++;
        if ({rd_en, rd_bank, rd_index} !== {1'b1, 2'd2, 8'hBD}) begin
            n_bad++; $display("FAIL single_rd got=%h exp=%h", {rd_en, rd_bank, rd_index}, {1'b1, 2'd2, 8'hBD});
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_t1 got=%b exp=0", out_valid); end
        @(negedge clk); #1;
        n_cmp++;
        if ({rd_en, out_valid} !== 2'b00) begin n_bad++; $display("FAIL single_t2 got=%b exp=00", {rd_en, out_valid}); end
        @(negedge clk); #1;
        n_cmp++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'hBF}) begin
            n_bad++; $display("FAIL single_out got=%h exp=%h", {out_valid, out_last, out_data}, {1'b1, 1'b1, 8'hBF});
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, req_ready, out_valid} !== 3'b010) begin
            n_bad++; $display("FAIL single_idle got=%b exp=010", {busy, req_ready, out_valid});
        end
    endtask

    task automatic test_wrap();
        logic [9:0] e_rd;
        logic [8:0] e_out;
        int c;
        fill_index();
        issue(10'h3FE, 8'd3);
        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            @(negedge clk); req_valid = 1'b0; out_ready = 1'b1; #1;
            if (rd_en) begin
                if (rd_q.size() != 0) e_rd = rd_q.pop_front(); else e_rd = 'x;
                n_cmp++;
                if ({rd_bank, rd_index} !== e_rd) begin n_bad++; $display("FAIL wrap_rd got=%h exp=%h", {rd_bank, rd_index}, e_rd); end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) e_out = exp_q.pop_front(); else e_out = 'x;
                n_cmp++;
                if ({out_last, out_data} !== e_out) begin n_bad++; $display("FAIL wrap_out got=%h exp=%h", {out_last, out_data}, e_out); end
            end
            c++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            n_bad++; $display("FAIL wrap_done got=%0d/%0d left exp=0/0", exp_q.size(), rd_q.size());
        end
    endtask

    task automatic test_long();
        logic [9:0] e_rd;
        logic [8:0] e_out;
        int c, bubbles, busy_low;
        bit started;
        fill_random();
        issue(10'h0C0, 8'd255);
        c = 0; bubbles = 0; busy_low = 0; started = 0;
        while (exp_q.size() != 0 && c < 400) begin
            @(negedge clk); req_valid = 1'b0; out_ready = 1'b1; #1;
            if (!busy) busy_low++;
            if (out_valid) started = 1;
            else if (started) bubbles++;
            if (rd_en) begin
                if (rd_q.size() != 0) e_rd = rd_q.pop_front(); else e_rd = 'x;
                n_cmp++;
                if ({rd_bank, rd_index} !== e_rd) begin n_bad++; $display("FAIL long_rd got=%h exp=%h", {rd_bank, rd_index}, e_rd); end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) e_out = exp_q.pop_front(); else e_out = 'x;
                n_cmp++;
                if ({out_last, out_data} !== e_out) begin n_bad++; $display("FAIL long_out got=%h exp=%h", {out_last, out_data}, e_out); end
            end
            c++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL long_done got=%0d left exp=0", exp_q.size()); end
        n_cmp++;
        if (bubbles != 0) begin n_bad++; $display("FAIL long_bubbles got=%0d exp=0", bubbles); end
        n_cmp++;
        if (busy_low != 0) begin n_bad++; $display("FAIL long_busy got=%0d low cycles exp=0", busy_low); end
    endtask

    task automatic test_stall();
        logic [9:0] e_rd;
        logic [8:0] e_out;
        logic [8:0] held_val;
        bit held, pop_now;
        int c, issued, popped, max_out;
        fill_random();
        issue(10'h123, 8'd7);
        c = 0; issued = 0; popped = 0; max_out = 0; held = 0; held_val = '0;
        while (exp_q.size() != 0 && c < 100) begin
            @(negedge clk); req_valid = 1'b0; out_ready = !(c >= 3 && c < 8); #1;
            pop_now = out_valid && out_ready;
            if (held && out_valid) begin
                n_cmp++;
                if ({out_last, out_data} !== held_val) begin n_bad++; $display("FAIL stall_hold got=%h exp=%h", {out_last, out_data}, held_val); end
            end
            held = out_valid && !out_ready;
            held_val = {out_last, out_data};
            if (rd_en) begin
                n_cmp++;
                if ((issued - popped - int'(pop_now)) >= 2) begin
                    n_bad++; $display("FAIL stall_overissue got=%0d outstanding exp=<2", issued - popped - int'(pop_now));
                end
                issued++;
                if (rd_q.size() != 0) e_rd = rd_q.pop_front(); else e_rd = 'x;
                n_cmp++;
                if ({rd_bank, rd_index} !== e_rd) begin n_bad++; $display("FAIL stall_rd got=%h exp=%h", {rd_bank, rd_index}, e_rd); end
            end
            if (pop_now) begin
                popped++;
                if (exp_q.size() != 0) e_out = exp_q.pop_front(); else e_out = 'x;
                n_cmp++;
                if ({out_last, out_data} !== e_out) begin n_bad++; $display("FAIL stall_out got=%h exp=%h", {out_last, out_data}, e_out); end
            end
            if (issued - popped > max_out) max_out = issued - popped;
            c++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_done got=%0d left exp=0", exp_q.size()); end
        n_cmp++;
        if (max_out != 2) begin n_bad++; $display("FAIL stall_max_outstanding got=%0d exp=2", max_out); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e_rd;
        logic [8:0] e_out;
        int c, popped, stale;
        fill_random();
        issue(10'h200, 8'd15);
        c = 0; popped = 0;
        while (popped < 3 && c < 50) begin
            @(negedge clk); req_valid = 1'b0; out_ready = 1'b1; #1;
            if (rd_en) begin
                if (rd_q.size() != 0) e_rd = rd_q.pop_front(); else e_rd = 'x;
                n_cmp++;
                if ({rd_bank, rd_index} !== e_rd) begin n_bad++; $display("FAIL rstmid_rd got=%h exp=%h", {rd_bank, rd_index}, e_rd); end
            end
            if (out_valid && out_ready) begin
                popped++;
                if (exp_q.size() != 0) e_out = exp_q.pop_front(); else e_out = 'x;
                n_cmp++;
                if ({out_last, out_data} !== e_out) begin n_bad++; $display("FAIL rstmid_out got=%h exp=%h", {out_last, out_data}, e_out); end
            end
            c++;
        end
        @(negedge clk); rst_n = 1'b0; #1;
        n_cmp++;
        if ({req_ready, rd_en, out_valid, out_last, busy} !== 5'b10000) begin
            n_bad++; $display("FAIL rstmid_state got=%b exp=10000", {req_ready, rd_en, out_valid, out_last, busy});
        end
        rd_q.delete();
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        issue(10'h010, 8'd3);
        c = 0; stale = 0;
        while ((exp_q.size() != 0 || c < 4) && c < 50) begin
            @(negedge clk); req_valid = 1'b0; out_ready = 1'b1; #1;
            if (rd_en) begin
                if (rd_q.size() != 0) e_rd = rd_q.pop_front(); else e_rd = 'x;
                n_cmp++;
                if ({rd_bank, rd_index} !== e_rd) begin n_bad++; $display("FAIL rstmid_rd2 got=%h exp=%h", {rd_bank, rd_index}, e_rd); end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) e_out = exp_q.pop_front(); else begin e_out = 'x; stale++; end
                n_cmp++;
                if ({out_last, out_data} !== e_out) begin n_bad++; $display("FAIL rstmid_out2 got=%h exp=%h", {out_last, out_data}, e_out); end
            end
            c++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || stale != 0) begin
            n_bad++; $display("FAIL rstmid_done got=%0d left/%0d stale exp=0/0", exp_q.size(), stale);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e_rd;
        logic [8:0] e_out;
        int c, accepts;
        bit prev_accept;
        fill_random();
        c = 0; accepts = 0; prev_accept = 0;
        req_addr = 10'h050; req_len = 8'd2;
        while ((accepts < 3 || exp_q.size() != 0) && c < 200) begin
            @(negedge clk); req_valid = (accepts < 3); out_ready = 1'b1; #1;
            if (prev_accept) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_after_accept got=%b exp=1", busy); end
            end
            if (busy) begin
                n_cmp++;
                if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_while_busy got=%b exp=0", req_ready); end
            end
            prev_accept = req_valid && req_ready;
            if (prev_accept) begin
                accepts++;
                push_burst(req_addr, req_len);
            end
            if (rd_en) begin
                if (rd_q.size() != 0) e_rd = rd_q.pop_front(); else e_rd = 'x;
                n_cmp++;
                if ({rd_bank, rd_index} !== e_rd) begin n_bad++; $display("FAIL b2b_rd got=%h exp=%h", {rd_bank, rd_index}, e_rd); end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) e_out = exp_q.pop_front(); else e_out = 'x;
                n_cmp++;
                if ({out_last, out_data} !== e_out) begin n_bad++; $display("FAIL b2b_out got=%h exp=%h", {out_last, out_data}, e_out); end
            end
            c++;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (accepts != 3 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_done got=%0d accepts/%0d left exp=3/0", accepts, exp_q.size());
        end
    endtask

    initial begin
        fill_index();
        test_reset();
        test_single();
        test_wrap();
        test_long();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_reader.md
MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 SHALL have parameters: ADDR_W 10 (byte address width); DATA_W 8 (byte width); FIFO_D 2 (output buffer depth).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req_valid  in  1  burst request valid.
REQ-005 SHALL have ports: req_ready  out  1  request accepted when high with req_valid.
REQ-006 SHALL have ports: req_addr  in  10  start byte address.
REQ-007 SHALL have ports: req_len  in  8  beats minus one (1..256 beats).
REQ-008 SHALL have ports: rd_en  out  1  bank read strobe.
REQ-009 SHALL have ports: rd_bank  out  2  bank select, equal to addr[9:8].
REQ-010 SHALL have ports: rd_index  out  8  bank row, equal to addr[7:0].
REQ-011 SHALL have ports: rd_data  in  8  bank read data, valid exactly one cycle after rd_en.
REQ-012 SHALL have ports: out_valid  out  1  output byte valid.
REQ-013 SHALL have ports: out_ready  in  1  consumer accepts byte.
REQ-014 SHALL have ports: out_data  out  8  output byte.
REQ-015 SHALL have ports: out_last  out  1  marks final beat of burst.
REQ-016 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, READ and DRAIN.
REQ-018 IDLE: req_ready=1; on req_valid&req_ready, latch addr and beats=req_len+1, then go to READ.
REQ-019 READ: issue one rd_en per cycle while beats_left>0 and (fifo_count + inflight - pop) < FIFO_D, where pop = out_valid&out_ready in the same cycle.
REQ-020 After each issue, addr SHALL increment modulo 1024, so 0x3FF wraps to 0x000, and beats_left SHALL decrement.
REQ-021 When the last read is issued, the FSM SHALL go to DRAIN; DRAIN SHALL return to IDLE in the cycle the last beat is popped.
REQ-022 rd_data SHALL be written into the FIFO on the cycle after rd_en; the FIFO SHALL never overflow (guaranteed by REQ-019).
REQ-023 Latency: handshake in cycle T gives rd_en in T+1 and first out_valid in T+3.
REQ-024 Throughput: with out_ready held high, the block SHALL sustain one beat per cycle.
REQ-025 out_valid SHALL equal FIFO not empty; out_data/out_last SHALL hold stable while out_valid&!out_ready.
REQ-026 out_last SHALL be set only on the beat from the final issued read; a 1-beat burst SHALL have out_last on its only beat.
REQ-027 req_ready SHALL be 0 outside IDLE; req_valid then has no effect.
REQ-028 rd_bank/rd_index SHALL be don't-care when rd_en=0, but driven from the addr register (no X).

Reset
REQ-029 rst_n low SHALL asynchronously force: state=IDLE, req_ready=1, rd_en=0, out_valid=0, out_last=0, busy=0, FIFO empty, inflight=0, beats_left=0, addr=0.
REQ-030 Reset mid-burst SHALL discard all buffered and in-flight data; a rd_data return after reset release SHALL be ignored.
REQ-031 The first request SHALL be accepted in the first cycle after rst_n deasserts.

Structure
REQ-032 Package mem_pkg SHALL hold ADDR_W, DATA_W, BANK_W=2, IDX_W=8 and the state enum (IDLE, READ, DRAIN).
REQ-033 The output buffer SHALL be a sub-module mem_rd_fifo (depth FIFO_D, width DATA_W+1 carrying data and last).
REQ-034 The design SHALL have no combinational path from out_ready to rd_en other than through the pop term of REQ-019.

Verification
REQ-035 Preload bank2[0xBD]=0xBF; request addr 0x2BD, len 0 -> rd_en with rd_bank=2 and rd_index=0xBD in T+1; out_data=0xBF with out_last=1 in T+3; then IDLE.
REQ-036 Request addr 0x3FE, len 3 with banks holding index as data -> rd_index sequence 0xFE, 0xFF, 0x00, 0x01; rd_bank sequence 3, 3, 0, 0; out_last on the 4th beat.
REQ-037 Request len 255 with out_ready=1 -> 256 consecutive beats with no bubble after the first, busy high throughout.
REQ-038 Request len 7; hold out_ready=0 for 5 cycles mid-burst -> rd_en stops once 2 bytes are outstanding, no data is lost or duplicated, and order is preserved.
REQ-039 Pulse rst_n low at beat 3 of a 16-beat burst -> all outputs go to reset values immediately; the next request returns correct data with no stale beats.
REQ-040 Hold req_valid high throughout a burst -> exactly one request is accepted per IDLE visit; req_ready=0 while busy.
